// File: rtl/rle_encoder_if.sv
// Handshake bundle for the RLE encoder: input sample stream, flush request
// and encoded output stream.
interface rle_encoder_if;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/rle_encoder.sv
// 16-bit run-length encoder: literals pass through, a repeated literal opens a
// run whose extra-repeat count follows as 0xFFFF continuation words plus a terminator.
module rle_encoder (
  input  logic         clk,
  input  logic         rst,
  rle_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LIT, RUN, HOLD} state_e;

  state_e      state_q, state_d;
  logic [15:0] prev_q, prev_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;

  logic        out_free;
  logic        in_rdy;
  logic        in_fire;
  logic        load;
  logic [15:0] load_data;

  always_comb begin
    out_free  = !out_valid_q || bus.out_ready;
    in_rdy    = !rst && (state_q != HOLD) && !bus.flush && out_free;
    in_fire   = bus.in_valid && in_rdy;
    state_d   = state_q;
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    load_data = out_data_q;

    case (state_q)
      IDLE: begin
        if (in_fire) begin
          load      = 1'b1;
          load_data = bus.in_data;
          prev_d    = bus.in_data;
          state_d   = LIT;
        end
      end
      LIT: begin
        if (in_fire) begin
          load      = 1'b1;
          load_data = bus.in_data;
          if (bus.in_data == prev_q) begin
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            prev_d  = bus.in_data;
          end
        end
      end
      RUN: begin
        // Flush blocks in_ready, so it never competes with an input transfer.
        if (bus.flush && out_free) begin
          load      = 1'b1;
          load_data = cnt_q;
          state_d   = IDLE;
        end else if (in_fire) begin
          if (bus.in_data == prev_q) begin
            if (cnt_q == 16'hFFFE) begin
              load      = 1'b1;
              load_data = '1;
              cnt_d     = '0;
            end else begin
              cnt_d     = cnt_q + 16'd1;
            end
          end else begin
            load      = 1'b1;
            load_data = cnt_q;
            prev_d    = bus.in_data;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        // The new literal waits in prev until the terminator has been taken.
        if (out_valid_q && bus.out_ready) begin
          load      = 1'b1;
          load_data = prev_q;
          state_d   = LIT;
        end
      end
      default: state_d = IDLE;
    endcase

    out_data_d  = load ? load_data : out_data_q;
    out_valid_d = load ? 1'b1 : (out_valid_q && !bus.out_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: doc/rle_encoder.md
RLE_ENCODER -- requirements
Module: rle_encoder

Interface
REQ-001 The block SHALL have no parameters; all data paths are fixed at 16 bits.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 in_data  input  16  raw sample word.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_ready  output  1  block accepts in_data this cycle; transfer = in_valid & in_ready.
REQ-007 flush  input  1  level request to terminate a pending run.
REQ-008 out_data  output  16  encoded word (literal or run-count), registered.
REQ-009 out_valid  output  1  out_data valid; held until taken.
REQ-010 out_ready  input  1  downstream takes out_data; output transfer = out_valid & out_ready.

Function
REQ-011 The output stream SHALL use this encoding: literals pass through; a literal equal to its predecessor literal opens a run; the next word is an extra-repeat count, where 0xFFFF means "65535 more, count continues" and any value below 0xFFFF terminates the run; the word after a terminator is a fresh literal that is never compared with the one before it.
REQ-012 The encoder SHALL be a four-state FSM: IDLE (no reference sample), LIT, RUN and HOLD, with a 16-bit prev register and a 16-bit cnt register.
REQ-013 in_ready SHALL be 1 iff state != HOLD, flush = 0 and (out_valid = 0 or out_ready = 1).
REQ-014 A word loaded into the output register SHALL set out_valid in the next cycle; an output transfer with no new load SHALL clear out_valid.
REQ-015 IDLE, on input transfer of s: the block SHALL load out_data = s, set prev = s and go to LIT.
REQ-016 LIT, on input s != prev: the block SHALL load out_data = s, set prev = s and stay in LIT.
REQ-017 LIT, on input s == prev: the block SHALL load out_data = s, clear cnt to 0 and go to RUN.
REQ-018 RUN, on input s == prev with cnt < 0xFFFE: the block SHALL increment cnt, emit nothing and stay in RUN.
REQ-019 RUN, on input s == prev with cnt == 0xFFFE: the block SHALL load out_data = 0xFFFF, clear cnt to 0 and stay in RUN.
REQ-020 RUN, on input s != prev: the block SHALL load out_data = cnt (always < 0xFFFF), store s in prev and go to HOLD.
REQ-021 HOLD, on output transfer: the block SHALL load out_data = prev, keep out_valid = 1 and go to LIT; in_ready stays 0 throughout HOLD.
REQ-022 In RUN with flush = 1 and (out_valid = 0 or out_ready = 1), the block SHALL load out_data = cnt and go to IDLE.
REQ-023 Flush in IDLE, LIT or HOLD SHALL be a no-op; in particular it SHALL NOT drop LIT to IDLE, because that would desynchronise the downstream comparison.
REQ-024 While out_valid = 1 and out_ready = 0, out_data SHALL be held stable and no state SHALL change.
REQ-025 A saturated run that ends immediately after a 0xFFFF word SHALL emit terminator 0x0000.

Reset
REQ-026 When rst = 1 at a rising edge, the block SHALL set state = IDLE, out_valid = 0, out_data = 0, prev = 0 and cnt = 0, in any state including mid-run and HOLD; the pending run and any held literal are discarded.
REQ-027 During and in the cycle of reset, in_ready SHALL be 0 and no input SHALL be consumed.

Verification
REQ-028 Inputs 0x0001, 0x0002, 0x0003, out_ready = 1 -> out 0x0001, 0x0002, 0x0003, no count words.
REQ-029 Inputs 5, 5, 5, 5, 7 -> out 5, 5, 2, 7; in_ready low exactly one cycle, during HOLD.
REQ-030 Inputs 5, 5, 7 -> out 5, 5, 0x0000, 7; next input 7 -> out 7 (LIT compare against 7, opens RUN).
REQ-031 65539 × 0x0005 then 0x0007 -> out 0x0005, 0x0005, 0xFFFF, 0x0002, 0x0007.
REQ-032 Inputs 9, 9, 9, then flush for 1 cycle -> out 9, 9, 1 and state IDLE; then 9 -> out 9. Flush asserted in LIT -> no output, in_ready = 0 while asserted.
REQ-033 Hold out_ready = 0 for 10 cycles with out_valid = 1 -> out_data stable and in_ready = 0; assert rst in HOLD -> out_valid = 0 next cycle and state IDLE.
